fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, issues single-outstanding reads to instruction

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants, state
// encodings and the prefetch queue entry layout.
package fetch_unit_pkg;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_STALE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {instr, pc+2} with a clear
// that takes priority over a same-cycle push or pop.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW:0]    FULL = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, queues returned words and hands them to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] pc2_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [15:0]   r_pc;
  logic          r_err;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_outstanding;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_ack_unexp;

  assign w_outstanding = (r_state == ST_WAIT) || (r_state == ST_STALE);

  // A slot is reserved when the read is issued, so the returning push can never overflow.
  assign w_issue = !rst && (r_state == ST_IDLE) && !redirect &&
                   ((int'(w_count) + int'(w_outstanding)) < DEPTH);

  // Decode handshake: the head transfers on any cycle where instr_valid && instr_ready;
  // instr_valid never depends on instr_ready. A redirect discards that cycle's push and pop.
  assign w_empty = (w_count == '0);
  assign w_push  = (r_state == ST_WAIT) && imem_ack && !redirect;
  assign w_pop   = !w_empty && instr_ready && !redirect;

  // While WAIT, r_pc already holds issued_pc+2: it only moves on issue or redirect.
  assign w_push_data = '{instr: imem_rdata, pc2: r_pc};

  fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_issue) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (redirect)      w_state_nxt = imem_ack ? ST_IDLE : ST_STALE;
        else if (imem_ack) w_state_nxt = is_halt(imem_rdata) ? ST_HALT : ST_IDLE;
      end
      ST_STALE: if (imem_ack) w_state_nxt = ST_IDLE;
      ST_HALT:  if (redirect) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ack_unexp = imem_ack && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)     r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + 16'd2;
      if (w_ack_unexp || (redirect && redirect_pc[0])) r_err <= 1'b1;
    end
  end

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr_out   = w_empty ? NOP_INSTR : w_head.instr;
  assign pc2_out     = w_empty ? 16'h0000 : w_head.pc2;
  assign halted      = (r_state == ST_HALT);
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder plus a program-order model of the
// instruction stream decode should see, driven by directed and random steps.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] instr_out;
  logic [15:0] pc2_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halted;
  logic        err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc2_out     (pc2_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];
  logic [15:0] exp_q[$];
  bit          pend, ack_now, prev_redirect, do_redirect, spur_ack;
  int          pend_cnt, fixed_lat, n_req, n_deliv, cyc, first_req_cyc, first_val_cyc;
  logic [15:0] pend_addr, fetch_pc, exp_pc, rd_pc, last_req_addr, saved_word;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; ack_now = 0; prev_redirect = 0; do_redirect = 0; spur_ack = 0;
    exp_q.delete();
    fetch_pc = RESET_PC; exp_pc = RESET_PC;
    n_req = 0; n_deliv = 0; cyc = 0; first_req_cyc = -1; first_val_cyc = -1;
    last_req_addr = 16'hxxxx;
  endtask

  // Called at posedge+1; asserts rst, checks outputs in that same cycle, releases it next cycle.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0;
    #1;
    check1("rst_imem_req", imem_req, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check16("rst_instr_out", instr_out, 16'h0800);
    check16("rst_pc2_out", pc2_out, 16'h0000);
    check1("rst_halted", halted, 1'b0);
    check1("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive memory/redirect inputs, observe, update the model.
  task automatic step();
    logic [15:0] w;
    ack_now = 0;
    imem_ack = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_ack = 1'b1; imem_rdata = mem[pend_addr[15:1]]; pend = 0; ack_now = 1;
      end else pend_cnt--;
    end
    if (spur_ack) begin imem_ack = 1'b1; imem_rdata = 16'h1234; end
    redirect = do_redirect; redirect_pc = rd_pc;
    #1;
    if (prev_redirect) check1("empty_after_redirect", instr_valid, 1'b0);
    if (redirect) check1("no_req_on_redirect", imem_req, 1'b0);
    if (!instr_valid) check16("nop_when_empty", instr_out, 16'h0800);
    if (imem_req) begin
      check1("single_outstanding", pend | ack_now, 1'b0);
      check16("req_addr", imem_addr, fetch_pc);
      check1("slot_reserved", exp_q.size() < DEPTH, 1'b1);
      exp_q.push_back(mem[fetch_pc[15:1]]);
      pend = 1; pend_addr = imem_addr;
      pend_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      last_req_addr = imem_addr; fetch_pc = fetch_pc + 16'd2; n_req++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) check1("unexpected_delivery", instr_valid, 1'b0);
      else begin
        w = exp_q.pop_front();
        check16("instr_out", instr_out, w);
        check16("pc2_out", pc2_out, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2; n_deliv++;
      end
    end
    prev_redirect = redirect;
    if (redirect) begin exp_q.delete(); fetch_pc = rd_pc; exp_pc = rd_pc; end
    do_redirect = 0; spur_ack = 0; cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000) w[15:11] = 5'b01000;
      mem[i] = w;
    end
    rd_pc = 16'h0;
    model_reset();
    @(posedge clk); #1;

    // 1: basic fetch, 1-cycle memory
    mem[0] = 16'h4100; mem[1] = 16'h4200;
    do_reset();
    instr_ready = 1'b1; fixed_lat = 1;
    for (int i = 0; i < 8; i++) step();
    check16("t1_first_req_cyc", 16'(first_req_cyc), 16'd0);
    check16("t1_req_to_valid", 16'(first_val_cyc - first_req_cyc), 16'd2);
    check1("t1_deliv_ge2", n_deliv >= 2, 1'b1);

    // 2: decode stalled, reservation limits reads to DEPTH
    do_reset();
    instr_ready = 1'b0; fixed_lat = 1;
    for (int i = 0; i < 10; i++) step();
    check16("t2_req_count_full", 16'(n_req), 16'd2);
    check1("t2_valid_full", instr_valid, 1'b1);
    check16("t2_head", instr_out, 16'h4100);
    instr_ready = 1'b1;
    step(); step();
    check16("t2_next_addr", last_req_addr, 16'h0004);
    check16("t2_deliv", 16'(n_deliv), 16'd2);

    // 3: redirect while a read is outstanding
    do_reset();
    instr_ready = 1'b0; fixed_lat = 1;
    step(); step();
    fixed_lat = 3;
    step();
    check1("t3_valid_before", instr_valid, 1'b1);
    do_redirect = 1; rd_pc = 16'h0040;
    for (int i = 0; i < 4; i++) step();
    check16("t3_redirect_addr", last_req_addr, 16'h0040);
    check16("t3_req_count", 16'(n_req), 16'd3);
    check1("t3_stale_ack_no_err", err, 1'b0);

    // 4: HALT word at address 6
    saved_word = mem[3]; mem[3] = 16'h0000;
    do_reset();
    instr_ready = 1'b1; fixed_lat = 1;
    for (int i = 0; i < 30; i++) step();
    check1("t4_halted", halted, 1'b1);
    check16("t4_req_count", 16'(n_req), 16'd4);
    check16("t4_deliv", 16'(n_deliv), 16'd4);
    do_redirect = 1; rd_pc = 16'h0010;
    step();
    check1("t4_unhalted", halted, 1'b0);
    step();
    check16("t4_redirect_addr", last_req_addr, 16'h0010);
    check16("t4_req_after", 16'(n_req), 16'd5);
    mem[3] = saved_word;

    // 5: protocol errors
    do_reset();
    spur_ack = 1;
    step(); step();
    check1("t5_err_set", err, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check1("t5_err_sticky", err, 1'b1);
    do_reset();
    do_redirect = 1; rd_pc = 16'h0003;
    step(); step();
    check1("t5_err_odd_pc", err, 1'b1);

    // 6: reset while WAIT with a queued word
    do_reset();
    instr_ready = 1'b0; fixed_lat = 1;
    step(); step();
    fixed_lat = 3;
    step();
    check16("t6_state_wait", 16'(dbg_state), 16'd1);
    check1("t6_valid", instr_valid, 1'b1);
    do_reset();
    step();
    check16("t6_req_after_rst", last_req_addr, RESET_PC);
    check16("t6_req_count", 16'(n_req), 16'd1);

    // Random traffic: random latency, decode stalls, redirects (some near the wrap)
    do_reset();
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        do_redirect = 1;
        if ($urandom_range(0, 7) == 0) rd_pc = 16'hFFFA;
        else rd_pc = 16'($urandom_range(0, 32767)) << 1;
      end
      step();
    end
    check1("rand_no_err", err, 1'b0);
    check1("rand_not_halted", halted, 1'b0);
    check1("rand_progress", n_deliv > 300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
